// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder10 cell fed LSB first over WIDTH clocks,
// with a registered carry loop and a one-cycle done pulse.

module full_adder10 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             fa_s;
    logic             fa_co;

    full_adder10 u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (c),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so the LSB-first stream lands in order.
    always_comb begin
        res_nxt            = res >> 1;
        res_nxt[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                SHIFT: begin
                    res  <= res_nxt;
                    c    <= fa_co;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_nxt;
                        cout  <= fa_co;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation.
                    if (start) begin
                        state <= SHIFT;
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        cnt   <= '0;
                        res   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH 1, 8 and 32: directed literal cases
// on the 8-bit instance plus random traffic against an a+b+cin model.

module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int wd[3] = '{1, 8, 32};

    logic        st[3];
    logic [31:0] av[3];
    logic [31:0] bv[3];
    logic        ci[3];
    logic        bz[3];
    logic        dn[3];
    logic        co[3];
    logic [31:0] sm[3];

    logic [0:0]  a1, b1, s1;
    logic [7:0]  a8, b8, s8;
    logic [31:0] a32, b32, s32;

    always_comb begin
        a1    = av[0][0:0];
        b1    = bv[0][0:0];
        a8    = av[1][7:0];
        b8    = bv[1][7:0];
        a32   = av[2];
        b32   = bv[2];
        sm[0] = {31'b0, s1};
        sm[1] = {24'b0, s8};
        sm[2] = s32;
    end

    serial_adder_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(st[0]), .a(a1), .b(b1), .cin(ci[0]),
        .busy(bz[0]), .done(dn[0]), .sum(s1), .cout(co[0])
    );
    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st[1]), .a(a8), .b(b8), .cin(ci[1]),
        .busy(bz[1]), .done(dn[1]), .sum(s8), .cout(co[1])
    );
    serial_adder_ctrl #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(st[2]), .a(a32), .b(b32), .cin(ci[2]),
        .busy(bz[2]), .done(dn[2]), .sum(s32), .cout(co[2])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference: an op takes WIDTH busy cycles, then one done cycle.
    int          left[3];
    int          ops[3];
    logic        edone[3];
    logic        ecout[3];
    logic [31:0] esum[3];
    logic [63:0] pv[3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            left[i]  = 0;
            ops[i]   = 0;
            edone[i] = 1'b0;
            ecout[i] = 1'b0;
            esum[i]  = '0;
            pv[i]    = '0;
            st[i]    = 1'b0;
            av[i]    = '0;
            bv[i]    = '0;
            ci[i]    = 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                left[i]  = 0;
                edone[i] = 1'b0;
                ecout[i] = 1'b0;
                esum[i]  = '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                edone[i] = 1'b0;
                if (left[i] > 0) begin
                    left[i]--;
                    if (left[i] == 0) begin
                        edone[i] = 1'b1;
                        esum[i]  = 32'(pv[i] & msk(wd[i]));
                        ecout[i] = pv[i][wd[i]];
                        ops[i]++;
                    end
                end else if (st[i]) begin
                    pv[i] = (64'(av[i]) & msk(wd[i]))
                          + (64'(bv[i]) & msk(wd[i]))
                          + 64'(ci[i]);
                    left[i] = wd[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy w%0d", wd[i]), 64'(bz[i]), 64'(left[i] > 0));
                chk($sformatf("done w%0d", wd[i]), 64'(dn[i]), 64'(edone[i]));
                chk($sformatf("sum w%0d", wd[i]), 64'(sm[i]), 64'(esum[i]));
                chk($sformatf("cout w%0d", wd[i]), 64'(co[i]), 64'(ecout[i]));
            end
        end
    end

    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       input logic c, input logic [7:0] es, input logic ec,
                       input int poke, input string nm);
        int  n;
        bit  got;
        got = 1'b0;
        @(negedge clk);
        st[1] = 1'b1;
        av[1] = {24'b0, x};
        bv[1] = {24'b0, y};
        ci[1] = c;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            st[1] = (n == poke);
            if (n == poke) begin
                av[1] = 32'h77;
                bv[1] = 32'h11;
            end
            if (dn[1]) begin
                got = 1'b1;
                break;
            end
        end
        st[1] = 1'b0;
        chk({nm, " done seen"}, 64'(got), 64'd1);
        chk({nm, " latency"}, 64'(n), 64'd9);
        chk({nm, " sum"}, 64'(sm[1]), 64'(es));
        chk({nm, " cout"}, 64'(co[1]), 64'(ec));
        @(negedge clk);
        chk({nm, " done pulse"}, 64'(dn[1]), 64'd0);
        chk({nm, " sum held"}, 64'(sm[1]), 64'(es));
    endtask

    task automatic wait_done8(input string nm, output int t);
        t = 0;
        while (!dn[1] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!dn[1]) chk({nm, " done timeout"}, 64'd0, 64'd1);
    endtask

    int base[3];
    int t;
    int ndone;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(bz[1]), 64'd0);
        chk("reset done", 64'(dn[1]), 64'd0);
        chk("reset sum", 64'(sm[1]), 64'd0);
        chk("reset cout", 64'(co[1]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, "5A+3C");
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "FF+01");
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, "FF+FF+1");
        op8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, "00+00+1");
        op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3, "start ignored");
        op8(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 0, "fresh ops");

        @(negedge clk);
        st[1] = 1'b1;
        av[1] = 32'h12;
        bv[1] = 32'h34;
        ci[1] = 1'b0;
        @(negedge clk);
        st[1] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", 64'(bz[1]), 64'd0);
        chk("async rst done", 64'(dn[1]), 64'd0);
        chk("async rst sum", 64'(sm[1]), 64'd0);
        chk("async rst cout", 64'(co[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn[1]) ndone++;
        end
        chk("no done after abort", 64'(ndone), 64'd0);
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, "after rst");

        @(negedge clk);
        st[1] = 1'b1;
        av[1] = 32'h01;
        bv[1] = 32'h01;
        ci[1] = 1'b0;
        @(negedge clk);
        av[1] = 32'h80;
        bv[1] = 32'h80;
        wait_done8("b2b first", t);
        chk("b2b first gap", 64'(t + 1), 64'd9);
        chk("b2b first sum", 64'(sm[1]), 64'h02);
        chk("b2b first cout", 64'(co[1]), 64'd0);
        @(negedge clk);
        wait_done8("b2b second", t);
        chk("b2b second gap", 64'(t + 1), 64'd9);
        chk("b2b second sum", 64'(sm[1]), 64'h00);
        chk("b2b second cout", 64'(co[1]), 64'd1);
        st[1] = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 3; i++) base[i] = ops[i];
        for (int cyc = 0; cyc < 70000; cyc++) begin
            @(negedge clk);
            if (ops[0] - base[0] >= 1000 && ops[1] - base[1] >= 1000 &&
                ops[2] - base[2] >= 1000)
                break;
            for (int i = 0; i < 3; i++) begin
                st[i] = ($urandom_range(0, 3) != 0);
                av[i] = $urandom;
                bv[i] = $urandom;
                ci[i] = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            chk($sformatf("random ops w%0d", wd[i]),
                64'(ops[i] - base[i] >= 1000), 64'd1);
        end
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
